// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: state encoding and line levels shared by the serial transmitter
package serial_tx_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
  localparam logic TX_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/serial_tx_dff.sv
// serial_tx_dff: single D flip-flop storage cell
module serial_tx_dff (
  input  logic c,
  input  logic d,
  output logic q
);
  always_ff @(posedge c) q <= d;
endmodule

// File: rtl/serial_tx_piso_shift.sv
// serial_tx_piso_shift: parallel-load, shift-right register with synchronous clear, built from D flip-flop cells
module serial_tx_piso_shift #(
  parameter int WIDTH = 4
) (
  input  logic             c,
  input  logic             clr,
  input  logic             ld,
  input  logic             sh,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] d;
  assign d = clr ? '0 : ld ? din : sh ? {1'b0, q[WIDTH-1:1]} : q;
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    serial_tx_dff u_dff (.c(c), .d(d[g]), .q(q[g]));
  end
endmodule

// File: rtl/serial_tx.sv
// serial_tx: frame transmitter sending start, LSB-first data, even parity and stop, one bit per clock
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             c,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             busy,
  output logic             tx
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t          state;
  logic [CW-1:0]   cnt;
  logic            par;
  logic [WIDTH-1:0] q;
  logic            accept;
  assign accept = state == IDLE && load;
  assign busy = ~ready;
  serial_tx_piso_shift #(.WIDTH(WIDTH)) u_shift (
    .c(c), .clr(rst), .ld(accept), .sh(state == DATA), .din(din), .q(q)
  );
  // tx is registered one bit ahead: each edge loads the level for the coming cycle
  always_ff @(posedge c) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      par   <= 1'b0;
      tx    <= TX_IDLE_LEVEL;
      ready <= 1'b1;
    end else begin
      case (state)
        IDLE: if (load) begin
          state <= START;
          cnt   <= '0;
          par   <= ^din;
          tx    <= 1'b0;
          ready <= 1'b0;
        end
        START: begin
          state <= DATA;
          tx    <= q[0];
        end
        DATA: begin
          tx <= cnt == LAST ? par : q[1];
          if (cnt == LAST) state <= PARITY;
          else cnt <= cnt + 1'b1;
        end
        PARITY: begin
          state <= STOP;
          tx    <= TX_IDLE_LEVEL;
        end
        STOP: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed scenario tests for serial_tx with hand-computed frames
module tb_serial_tx;
  logic c = 1'b0;
  logic rst, load;
  logic [3:0] din;
  logic ready, busy, tx;
  int tests = 0;
  int fails = 0;
  logic [6:0] f;

  serial_tx #(.WIDTH(4)) dut (
    .c(c), .rst(rst), .load(load), .din(din), .ready(ready), .busy(busy), .tx(tx)
  );

  always #5 c = ~c;

  // samples the seven frame bits starting at the current falling edge (index 0 = start bit)
  task automatic capture(output logic [6:0] bits);
    for (int i = 0; i < 7; i++) begin
      bits[i] = tx;
      if (i < 6) @(negedge c);
    end
  endtask

  task automatic accept(input logic [3:0] w);
    @(negedge c);
    load = 1'b1;
    din  = w;
    @(negedge c);
    load = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge c);
    rst = 1'b1; load = 1'b1; din = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      @(negedge c);
      tests++;
      if ({tx, ready, busy} !== 3'b110) begin
        fails++;
        $display("FAIL reset_hold cyc%0d tx/ready/busy=%b expected 110", i, {tx, ready, busy});
      end
    end
    rst = 1'b0; load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge c);
      tests++;
      if ({tx, ready, busy} !== 3'b110) begin
        fails++;
        $display("FAIL reset_nostart cyc%0d tx/ready/busy=%b expected 110", i, {tx, ready, busy});
      end
    end
  endtask

  task automatic test_frame(input logic [3:0] w, input logic [6:0] exp, input string name);
    accept(w);
    tests++;
    if ({ready, busy} !== 2'b01) begin
      fails++;
      $display("FAIL %s_busy ready/busy=%b expected 01", name, {ready, busy});
    end
    capture(f);
    tests++;
    if (f !== exp) begin
      fails++;
      $display("FAIL %s_frame got=%b expected=%b", name, f, exp);
    end
    @(negedge c);
    tests++;
    if ({tx, ready, busy} !== 3'b110) begin
      fails++;
      $display("FAIL %s_done tx/ready/busy=%b expected 110", name, {tx, ready, busy});
    end
  endtask

  task automatic test_load_while_busy;
    accept(4'b0110);
    for (int i = 0; i < 7; i++) begin
      f[i] = tx;
      if (i == 2) begin load = 1'b1; din = 4'b1001; end
      if (i == 3) load = 1'b0;
      if (i < 6) @(negedge c);
    end
    tests++;
    if (f !== 7'b1001100) begin
      fails++;
      $display("FAIL busy_load_frame got=%b expected=%b", f, 7'b1001100);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge c);
      tests++;
      if ({tx, ready} !== 2'b11) begin
        fails++;
        $display("FAIL busy_load_idle cyc%0d tx/ready=%b expected 11", i, {tx, ready});
      end
    end
  endtask

  task automatic test_mid_reset;
    accept(4'b1011);
    @(negedge c);
    @(negedge c);
    tests++;
    if (tx !== 1'b1) begin
      fails++;
      $display("FAIL midrst_d1 tx=%b expected 1", tx);
    end
    rst = 1'b1;
    @(negedge c);
    rst = 1'b0;
    tests++;
    if ({tx, ready, busy} !== 3'b110) begin
      fails++;
      $display("FAIL midrst_idle tx/ready/busy=%b expected 110", {tx, ready, busy});
    end
    @(negedge c);
    tests++;
    if ({tx, ready} !== 2'b11) begin
      fails++;
      $display("FAIL midrst_stay tx/ready=%b expected 11", {tx, ready});
    end
    test_frame(4'b0001, 7'b1100010, "after_rst");
  endtask

  task automatic test_back_to_back;
    @(negedge c);
    load = 1'b1; din = 4'b1100;
    @(negedge c);
    for (int n = 0; n < 2; n++) begin
      capture(f);
      tests++;
      if (f !== 7'b1011000) begin
        fails++;
        $display("FAIL b2b_frame%0d got=%b expected=%b", n, f, 7'b1011000);
      end
      if (n == 1) load = 1'b0;
      @(negedge c);
      tests++;
      if ({tx, ready} !== 2'b11) begin
        fails++;
        $display("FAIL b2b_gap%0d tx/ready=%b expected 11", n, {tx, ready});
      end
      @(negedge c);
    end
    tests++;
    if ({tx, ready} !== 2'b11) begin
      fails++;
      $display("FAIL b2b_end tx/ready=%b expected 11", {tx, ready});
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; din = '0;
    repeat (2) @(posedge c);
    test_reset;
    test_frame(4'b1011, 7'b1110110, "basic");
    test_frame(4'b0000, 7'b1000000, "zero");
    test_frame(4'b1111, 7'b1011110, "ones");
    test_load_while_busy;
    test_mid_reset;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-in, serial-out frame transmitter built on the team's D flip-flop storage primitives. It captures a WIDTH-bit word on a load handshake and sends it as one frame: start bit, data LSB-first, even parity bit, stop bit, one bit per clock. It is the sending end of the team's serial link and drives the line that the serial receiver samples.

## Interface
- WIDTH, default 4: data bits per frame; legal range 2–8.
- c  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising edge of c.
- load  input  1  request to transmit din; honoured only when ready=1.
- din  input  WIDTH  word to send; sampled on the accepting edge only.
- ready  output  1  high when idle and able to accept load.
- busy  output  1  high while a frame is on the line; always equal to ~ready.
- tx  output  1  serial line; idle level 1.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, ready=1. Rising edge with load=1 captures din into the shift register, clears bit counter, computes parity register = XOR of din, goes to START.
- START: tx=0 for one cycle -> DATA.
- DATA: tx=shift[0]; each edge shifts right by one and increments the counter; after WIDTH bits -> PARITY. Counter is ceil(log2(WIDTH)) bits wide; compare against WIDTH-1, no wrap-around beyond that value.
- PARITY: tx=parity register (even parity: total ones over data+parity is even) -> STOP.
- STOP: tx=1 for one cycle -> IDLE.
- load in any state other than IDLE is ignored; din changes while busy do not affect the frame in flight.
- Reset (any state, including mid-frame): next edge -> IDLE, tx=1, ready=1, busy=0, shift register and counter cleared. rst=1 together with load=1: reset wins, no frame starts.
- Outputs are registered; no combinational path from load/din to tx.

## Timing
- Reset values: tx=1, ready=1, busy=0.
- Accept edge k (IDLE, load=1): ready=0/busy=1 from edge k; start bit on tx during cycle k..k+1.
- Data bit i on tx during cycle k+1+i, i=0..WIDTH-1; parity at k+1+WIDTH; stop at k+2+WIDTH.
- Frame length WIDTH+3 cycles. ready returns to 1 at edge k+WIDTH+3; earliest next accept is that same edge's following edge, giving back-to-back frames with one idle-level cycle between stop bit and next start bit... correction: stop bit counts as the idle-level gap, so a load held high yields continuous frames every WIDTH+4 cycles (stop plus one IDLE cycle).
- Latency load-accept to first tx change: 1 cycle.

## Structure
- Shared package: state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit), TX_IDLE_LEVEL=1.
- One sub-module is natural: piso_shift (WIDTH-bit parallel-load, shift-right register with load/shift enables and synchronous clear), built from DFlipFlop cells. FSM, counter, parity register stay in serial_tx.

## Test plan
- Reset: hold rst=1 two cycles with load=1, din=4'b1111 -> tx=1, ready=1, busy=0 throughout; no start bit.
- Basic frame: WIDTH=4, load=1 with din=4'b1011 for one cycle -> tx = 0,1,1,0,1,1,1 (start, d0..d3, parity=1, stop), then ready=1.
- Zero word: din=4'b0000 -> tx = 0,0,0,0,0,0,1; parity bit 0.
- Load while busy: accept din=4'b0110, then pulse load with din=4'b1001 in cycle 3 -> frame stays 0,0,1,1,0,0,1; second word never sent.
- Mid-frame reset: accept din=4'b1011, assert rst during second data bit -> tx=1, ready=1 from next edge; subsequent load of 4'b0001 sends 0,1,0,0,0,1,1.
- Back-to-back: load held high, din=4'b1100 -> frames repeat every 7+1 cycles, each 0,0,0,1,1,0,1 followed by one tx=1 idle cycle.
